nonce_scheduler: RTL
====================

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, range 1..16: number of parallel double-SHA256 cores driven.
REQ-002 SHALL have parameter CORE_LAT, default 64: fixed core latency in cycles, issue to result; used only for documentation and bench checks.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  in  1  one-cycle job start pulse.
REQ-006 SHALL have port stop  in  1  one-cycle abort pulse.
REQ-007 SHALL have port stop_on_found  in  1  mode select, sampled with start: 1 = halt at first hit, 0 = sweep whole range.
REQ-008 SHALL have port first_block_hash  in  256  midstate of the job.
REQ-009 SHALL have port second_block  in  128  block tail; bits [31:0] are ignored (nonce slot).
REQ-010 SHALL have port target  in  256  hit threshold.
REQ-011 SHALL have port start_nonce / max_nonce  in  32 each  inclusive nonce range.
REQ-012 SHALL have port job_hash  out  256  and job_tail  out  96: latched job, held constant to the cores.
REQ-013 SHALL have port core_valid  out  NUM_CORES  per-lane issue strobe.
REQ-014 SHALL have port core_nonce  out  32*NUM_CORES  lane i nonce in bits [32i+31:32i].
REQ-015 SHALL have port res_valid  in  NUM_CORES  and res_hash  in  256*NUM_CORES: in-order core results.
REQ-016 SHALL have outputs running (1), found (1), nonce (32), hit_count (16), aborted (1).

Function
REQ-017 SHALL implement states IDLE, ISSUE, DRAIN.
- IDLE->ISSUE: on start.
- ISSUE->DRAIN: on last group issued, stop, or a hit while stop_on_found.
- DRAIN->IDLE: when outstanding == 0.
REQ-018 SHALL, on start in IDLE, latch first_block_hash, second_block[127:32], target, max_nonce and stop_on_found; set base = start_nonce; clear hit_count, found and aborted.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL, in ISSUE each cycle, drive core_nonce lane i = base+i and set core_valid[i] only if base+i <= max_nonce, computed in 33 bits with no 32-bit wrap; then base += NUM_CORES.
REQ-021 SHALL treat the last group as the group where base+NUM_CORES-1 >= max_nonce; core_valid SHALL be 0 in IDLE and DRAIN.
REQ-022 SHALL track outstanding groups: +1 per issue cycle with any core_valid set, -1 per cycle with res_valid[0] set; simultaneous events cancel.
REQ-023 SHALL keep res_base (start at start_nonce, += NUM_CORES per result group); lane i result nonce = res_base+i.
REQ-024 SHALL count lane i as a hit when res_valid[i] and res_hash lane i < target, as strict unsigned 256-bit compare.
REQ-025 SHALL, per result cycle with one or more hits, pulse found for one cycle, set nonce to the lowest-index hit lane nonce (held until next found or start), and add popcount of hits to hit_count, saturating at 0xFFFF.
REQ-026 SHALL, in stop_on_found mode, stop issuing the cycle after the first hit and ignore (no found, no count) all later results; outstanding still decrements.
REQ-027 SHALL, on stop in ISSUE, set aborted=1 and go to DRAIN; results during that DRAIN are still evaluated.
REQ-028 SHALL ignore stop in IDLE.
REQ-029 SHALL drive running=1 in ISSUE and DRAIN, 0 in IDLE; found and stop in the same cycle are both honoured.
REQ-030 SHALL, for start_nonce > max_nonce, issue nothing and return to IDLE within 2 cycles with hit_count=0.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-job, force IDLE and zero all outputs, base, res_base and outstanding; in-flight results after release SHALL be ignored.

Verification
REQ-032 NUM_CORES=4, start_nonce=0x08FFFFF0, max_nonce=0xFFFFFFFF, hash target where only nonce 0x09000003 hashes equal to target-1 -> found once, nonce=0x09000003, hit_count=1, running drops after sweep/drain.
REQ-033 Same job with target lowered by 1 (hash == target) -> no found, hit_count=0.
REQ-034 start_nonce=0xFFFFFFFE, max_nonce=0xFFFFFFFF, NUM_CORES=4 -> one group, core_valid=4'b0011, no wrap to nonce 0.
REQ-035 Lanes 1 and 3 hit in same group, stop_on_found=1 -> nonce=lane 1 value, hit_count=2, no further issue, running falls after CORE_LAT drain.
REQ-036 stop pulse 10 cycles into ISSUE -> aborted=1, exactly 10 groups accounted, running=0 after drain.
REQ-037 rst_n low during DRAIN -> all outputs 0 next edge; late res_valid ignored; new start works normally.

Source files
------------

// File: rtl/nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nonce_scheduler
// Description : Sweeps a nonce range across NUM_CORES double-SHA256 cores,
//               one group of NUM_CORES consecutive nonces per cycle, and
//               checks the in-order results against a 256-bit target.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int CORE_LAT  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     stop_on_found,
    input  logic [255:0]             first_block_hash,
    input  logic [127:0]             second_block,
    input  logic [255:0]             target,
    input  logic [31:0]              start_nonce,
    input  logic [31:0]              max_nonce,
    output logic [255:0]             job_hash,
    output logic [95:0]              job_tail,
    output logic [NUM_CORES-1:0]     core_valid,
    output logic [32*NUM_CORES-1:0]  core_nonce,
    input  logic [NUM_CORES-1:0]     res_valid,
    input  logic [256*NUM_CORES-1:0] res_hash,
    output logic                     running,
    output logic                     found,
    output logic [31:0]              nonce,
    output logic [15:0]              hit_count,
    output logic                     aborted
);

    // Enough headroom for every group that can be in flight inside the cores.
    localparam int          OUT_W = $clog2(CORE_LAT + 2) + 1;
    localparam logic [32:0] NC33  = 33'(NUM_CORES);
    localparam logic [31:0] NC32  = 32'(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [255:0]       job_hash_q, job_hash_d;
    logic [95:0]        job_tail_q, job_tail_d;
    logic [255:0]       target_q, target_d;
    logic [31:0]        max_q, max_d;
    logic               sof_q, sof_d;
    logic               halted_q, halted_d;
    logic [32:0]        base_q, base_d;      // 33 bits so the sweep never wraps
    logic [31:0]        res_base_q, res_base_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               found_q, found_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [15:0]        hit_count_q, hit_count_d;
    logic               aborted_q, aborted_d;

    logic [32:0]          w_lane;
    logic                 w_take;
    logic [NUM_CORES-1:0] w_hit;
    logic [4:0]           w_pop;
    logic [31:0]          w_first;
    logic [16:0]          w_sum;
    logic                 w_last;
    logic                 w_issue;

    // The nonce slot of the block tail is supplied by the cores themselves.
    logic unused_nonce_slot;
    assign unused_nonce_slot = ^second_block[31:0];

    // Lane nonces and issue strobes for the current group; silent outside ISSUE.
    always_comb begin
        core_valid = '0;
        core_nonce = '0;
        w_lane     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_lane = base_q + 33'(i);
            if (state_q == ISSUE) begin
                core_nonce[32*i +: 32] = w_lane[31:0];
                core_valid[i]          = (w_lane <= {1'b0, max_q});
            end
        end
    end

    // Result evaluation: per-lane hits, popcount and lowest hitting lane.
    always_comb begin
        w_take  = res_valid[0] && (out_q != '0);
        w_hit   = '0;
        w_pop   = '0;
        w_first = '0;
        // Descending scan so the last assignment is the lowest-index hit.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_hit[i] = w_take && res_valid[i] && !halted_q &&
                       (res_hash[256*i +: 256] < target_q);
            if (w_hit[i]) begin
                w_first = 32'(i);
            end
            w_pop = w_pop + {4'd0, w_hit[i]};
        end
        w_sum   = {1'b0, hit_count_q} + {12'd0, w_pop};
        w_last  = (base_q + NC33 - 33'd1) >= {1'b0, max_q};
        w_issue = (state_q == ISSUE) && (core_valid != '0);
    end

    // Next-state logic for the job FSM, nonce counters and result status.
    always_comb begin
        state_d     = state_q;
        job_hash_d  = job_hash_q;
        job_tail_d  = job_tail_q;
        target_d    = target_q;
        max_d       = max_q;
        sof_d       = sof_q;
        halted_d    = halted_q;
        base_d      = base_q;
        res_base_d  = res_base_q;
        out_d       = out_q + (w_issue ? OUT_W'(1) : '0) - (w_take ? OUT_W'(1) : '0);
        found_d     = 1'b0;
        nonce_d     = nonce_q;
        hit_count_d = hit_count_q;
        aborted_d   = aborted_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    job_hash_d  = first_block_hash;
                    job_tail_d  = second_block[127:32];
                    target_d    = target;
                    max_d       = max_nonce;
                    sof_d       = stop_on_found;
                    halted_d    = 1'b0;
                    base_d      = {1'b0, start_nonce};
                    res_base_d  = start_nonce;
                    nonce_d     = '0;
                    hit_count_d = '0;
                    aborted_d   = 1'b0;
                end
            end
            ISSUE: begin
                base_d = base_q + NC33;
                if (stop) begin
                    aborted_d = 1'b1;
                end
                if (w_last || stop || (sof_q && (w_hit != '0))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_take) begin
            res_base_d = res_base_q + NC32;
        end
        if (w_hit != '0) begin
            found_d     = 1'b1;
            nonce_d     = res_base_q + w_first;
            hit_count_d = w_sum[16] ? 16'hFFFF : w_sum[15:0];
            if (sof_q) begin
                halted_d = 1'b1;
            end
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            job_hash_q  <= '0;
            job_tail_q  <= '0;
            target_q    <= '0;
            max_q       <= '0;
            sof_q       <= 1'b0;
            halted_q    <= 1'b0;
            base_q      <= '0;
            res_base_q  <= '0;
            out_q       <= '0;
            found_q     <= 1'b0;
            nonce_q     <= '0;
            hit_count_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_hash_q  <= job_hash_d;
            job_tail_q  <= job_tail_d;
            target_q    <= target_d;
            max_q       <= max_d;
            sof_q       <= sof_d;
            halted_q    <= halted_d;
            base_q      <= base_d;
            res_base_q  <= res_base_d;
            out_q       <= out_d;
            found_q     <= found_d;
            nonce_q     <= nonce_d;
            hit_count_q <= hit_count_d;
            aborted_q   <= aborted_d;
        end
    end

    assign job_hash  = job_hash_q;
    assign job_tail  = job_tail_q;
    assign running   = (state_q != IDLE);
    assign found     = found_q;
    assign nonce     = nonce_q;
    assign hit_count = hit_count_q;
    assign aborted   = aborted_q;

endmodule
`default_nettype wire
